// File: rtl/axi_lite_ctrl_regs.sv
// AXI4-Lite control/status register block for the TPC grid.
// Holds the per-TPC enable mask, pulses TPC start, tracks per-TPC completion
// and raises a level completion interrupt.
module axi_lite_ctrl_regs #(
  parameter int          NUM_TPC = 4,
  parameter int          ADDR_W  = 12,
  parameter logic [31:0] VERSION = 32'h0001_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  s_axi_ctrl_awaddr,
  input  logic               s_axi_ctrl_awvalid,
  output logic               s_axi_ctrl_awready,
  input  logic [31:0]        s_axi_ctrl_wdata,
  input  logic [3:0]         s_axi_ctrl_wstrb,
  input  logic               s_axi_ctrl_wvalid,
  output logic               s_axi_ctrl_wready,
  output logic [1:0]         s_axi_ctrl_bresp,
  output logic               s_axi_ctrl_bvalid,
  input  logic               s_axi_ctrl_bready,
  input  logic [ADDR_W-1:0]  s_axi_ctrl_araddr,
  input  logic               s_axi_ctrl_arvalid,
  output logic               s_axi_ctrl_arready,
  output logic [31:0]        s_axi_ctrl_rdata,
  output logic [1:0]         s_axi_ctrl_rresp,
  output logic               s_axi_ctrl_rvalid,
  input  logic               s_axi_ctrl_rready,
  output logic [NUM_TPC-1:0] tpc_enable,
  output logic [NUM_TPC-1:0] tpc_start,
  input  logic [NUM_TPC-1:0] tpc_busy,
  input  logic [NUM_TPC-1:0] tpc_done,
  output logic               irq
);

  localparam int AW = ADDR_W - 2;
  localparam logic [AW-1:0] W_CTRL     = AW'(0);
  localparam logic [AW-1:0] W_STATUS   = AW'(1);
  localparam logic [AW-1:0] W_IRQ_PEND = AW'(2);
  localparam logic [AW-1:0] W_IRQ_EN   = AW'(3);
  localparam logic [AW-1:0] W_VERSION  = AW'(4);
  localparam logic [1:0]    RESP_OKAY   = 2'b00;
  localparam logic [1:0]    RESP_SLVERR = 2'b10;

  logic              aw_held;
  logic [ADDR_W-1:0] aw_addr_q;
  logic              w_held;
  logic [31:0]       w_data_q;
  logic [3:0]        w_strb_q;
  logic              bvalid_q;
  logic [1:0]        bresp_q;
  logic              rvalid_q;
  logic [31:0]       rdata_q;
  logic [1:0]        rresp_q;

  logic [NUM_TPC-1:0] enable_q;
  logic [NUM_TPC-1:0] start_q;
  logic [NUM_TPC-1:0] done_q;
  logic               run_q;
  logic               pend_q;
  logic               irq_en_q;

  logic              aw_fire, w_fire, ar_fire, commit;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strb;
  logic [AW-1:0]     wr_word, rd_word;
  logic              wr_ok, wr_ctrl, start_go, pend_clr, done_all;
  logic [NUM_TPC-1:0] new_en;
  logic [31:0]       rd_val;
  logic [1:0]        rd_resp;
  logic              unused_bits;

  // Channel readiness: held low during reset and while a slot or response is occupied.
  always_comb begin
    s_axi_ctrl_awready = ~rst & ~aw_held & ~bvalid_q;
    s_axi_ctrl_wready  = ~rst & ~w_held & ~bvalid_q;
    s_axi_ctrl_arready = ~rst & ~rvalid_q;
  end

  // Write-side decode: merge latched and arriving AW/W, compute register side effects.
  always_comb begin
    aw_fire  = s_axi_ctrl_awvalid & s_axi_ctrl_awready;
    w_fire   = s_axi_ctrl_wvalid & s_axi_ctrl_wready;
    ar_fire  = s_axi_ctrl_arvalid & s_axi_ctrl_arready;
    commit   = (aw_held | aw_fire) & (w_held | w_fire);
    wr_addr  = aw_held ? aw_addr_q : s_axi_ctrl_awaddr;
    wr_data  = w_held ? w_data_q : s_axi_ctrl_wdata;
    wr_strb  = w_held ? w_strb_q : s_axi_ctrl_wstrb;
    wr_word  = wr_addr[ADDR_W-1:2];
    wr_ok    = (wr_word == W_CTRL) || (wr_word == W_STATUS) || (wr_word == W_IRQ_PEND) ||
               (wr_word == W_IRQ_EN) || (wr_word == W_VERSION);
    wr_ctrl  = commit & (wr_word == W_CTRL);
    new_en   = (wr_ctrl & wr_strb[1]) ? wr_data[8 +: NUM_TPC] : enable_q;
    start_go = wr_ctrl & wr_strb[0] & wr_data[0] & (|new_en);
    pend_clr = commit & (wr_word == W_IRQ_PEND) & wr_strb[0] & wr_data[0];
    done_all = run_q & ((done_q & enable_q) == enable_q);
  end

  // Read mux over the current (pre-write) register state.
  always_comb begin
    rd_word = s_axi_ctrl_araddr[ADDR_W-1:2];
    rd_val  = '0;
    rd_resp = RESP_OKAY;
    case (rd_word)
      W_CTRL:     rd_val[8 +: NUM_TPC] = enable_q;
      W_STATUS: begin
        rd_val[0 +: NUM_TPC] = tpc_busy;
        rd_val[8 +: NUM_TPC] = done_q;
        rd_val[16]           = run_q;
      end
      W_IRQ_PEND: rd_val[0] = pend_q;
      W_IRQ_EN:   rd_val[0] = irq_en_q;
      W_VERSION:  rd_val    = VERSION;
      default:    rd_resp   = RESP_SLVERR;
    endcase
  end

  // Write channel: one-entry AW/W latches and the B response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_held   <= 1'b0;
      aw_addr_q <= '0;
      w_held    <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      if (commit) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else begin
        if (aw_fire) begin
          aw_held   <= 1'b1;
          aw_addr_q <= s_axi_ctrl_awaddr;
        end
        if (w_fire) begin
          w_held   <= 1'b1;
          w_data_q <= s_axi_ctrl_wdata;
          w_strb_q <= s_axi_ctrl_wstrb;
        end
        if (bvalid_q && s_axi_ctrl_bready) bvalid_q <= 1'b0;
      end
    end
  end

  // Read channel: registered data/response held until rready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_fire) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_val;
      rresp_q  <= rd_resp;
    end else if (rvalid_q && s_axi_ctrl_rready) begin
      rvalid_q <= 1'b0;
    end
  end

  // Control state: enable mask, start pulse, sticky done, run tracking, interrupt.
  // A done pulse is OR-ed in after the start clear so set wins on the same bit;
  // likewise the pending set takes priority over a same-cycle W1C.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable_q <= '0;
      start_q  <= '0;
      done_q   <= '0;
      run_q    <= 1'b0;
      pend_q   <= 1'b0;
      irq_en_q <= 1'b0;
    end else begin
      enable_q <= new_en;
      start_q  <= start_go ? new_en : '0;
      done_q   <= (done_q & ~(start_go ? new_en : '0)) | tpc_done;
      if (start_go)      run_q <= 1'b1;
      else if (done_all) run_q <= 1'b0;
      if (done_all)      pend_q <= 1'b1;
      else if (pend_clr) pend_q <= 1'b0;
      if (commit && (wr_word == W_IRQ_EN) && wr_strb[0]) irq_en_q <= wr_data[0];
    end
  end

  assign s_axi_ctrl_bvalid = bvalid_q;
  assign s_axi_ctrl_bresp  = bresp_q;
  assign s_axi_ctrl_rvalid = rvalid_q;
  assign s_axi_ctrl_rdata  = rdata_q;
  assign s_axi_ctrl_rresp  = rresp_q;
  assign tpc_enable        = enable_q;
  assign tpc_start         = start_q;
  assign irq               = pend_q & irq_en_q;
  assign unused_bits       = ^{wr_data, wr_strb, wr_addr[1:0], s_axi_ctrl_araddr[1:0]};

endmodule

// File: tb/tb_axi_lite_ctrl_regs.sv
// Directed bench for axi_lite_ctrl_regs: register map, start/done/irq flow,
// split AW/W timing with B back-pressure, unmapped access and mid-transaction reset.
module tb_axi_lite_ctrl_regs;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [11:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [3:0]  tpc_enable, tpc_start;
  logic [3:0]  tpc_busy = '0;
  logic [3:0]  tpc_done = '0;
  logic        irq;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  axi_lite_ctrl_regs #(.NUM_TPC(4), .ADDR_W(12), .VERSION(32'h0001_0000)) dut (
    .clk(clk), .rst(rst),
    .s_axi_ctrl_awaddr(awaddr), .s_axi_ctrl_awvalid(awvalid), .s_axi_ctrl_awready(awready),
    .s_axi_ctrl_wdata(wdata), .s_axi_ctrl_wstrb(wstrb), .s_axi_ctrl_wvalid(wvalid),
    .s_axi_ctrl_wready(wready), .s_axi_ctrl_bresp(bresp), .s_axi_ctrl_bvalid(bvalid),
    .s_axi_ctrl_bready(bready), .s_axi_ctrl_araddr(araddr), .s_axi_ctrl_arvalid(arvalid),
    .s_axi_ctrl_arready(arready), .s_axi_ctrl_rdata(rdata), .s_axi_ctrl_rresp(rresp),
    .s_axi_ctrl_rvalid(rvalid), .s_axi_ctrl_rready(rready),
    .tpc_enable(tpc_enable), .tpc_start(tpc_start), .tpc_busy(tpc_busy),
    .tpc_done(tpc_done), .irq(irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Full write from a negedge; returns the response and tpc_start seen with bvalid.
  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output logic [3:0] st);
    logic fa, fw;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    for (int i = 0; i < 20 && (awvalid || wvalid); i++) begin
      fa = awvalid & awready;
      fw = wvalid & wready;
      @(negedge clk);
      if (fa) awvalid = 1'b0;
      if (fw) wvalid = 1'b0;
    end
    for (int i = 0; i < 20 && !bvalid; i++) @(negedge clk);
    chk("wr_bvalid_seen", {31'd0, bvalid}, 32'd1);
    resp = bresp; st = tpc_start;
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp);
    logic fa;
    araddr = a; arvalid = 1'b1;
    for (int i = 0; i < 20 && arvalid; i++) begin
      fa = arvalid & arready;
      @(negedge clk);
      if (fa) arvalid = 1'b0;
    end
    for (int i = 0; i < 20 && !rvalid; i++) @(negedge clk);
    chk("rd_rvalid_seen", {31'd0, rvalid}, 32'd1);
    d = rdata; resp = rresp;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  initial begin
    logic [1:0]  resp;
    logic [3:0]  st;
    logic [31:0] d;
    int          bcnt;

    // 1. reset state, enable write without start
    @(negedge clk);
    chk("rst_awready", {31'd0, awready}, 32'd0);
    chk("rst_wready",  {31'd0, wready},  32'd0);
    chk("rst_arready", {31'd0, arready}, 32'd0);
    chk("rst_bvalid",  {31'd0, bvalid},  32'd0);
    chk("rst_rvalid",  {31'd0, rvalid},  32'd0);
    chk("rst_enable",  {28'd0, tpc_enable}, 32'd0);
    chk("rst_start",   {28'd0, tpc_start},  32'd0);
    chk("rst_irq",     {31'd0, irq},     32'd0);
    chk("rst_rdata",   rdata,            32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_awready", {31'd0, awready}, 32'd1);
    axi_write(12'h000, 32'h0000_0F00, 4'hF, resp, st);
    chk("t1_bresp",  {30'd0, resp}, 32'd0);
    chk("t1_start",  {28'd0, st},   32'd0);
    chk("t1_enable", {28'd0, tpc_enable}, 32'hF);
    axi_read(12'h000, d, resp);
    chk("t1_ctrl_rd", d, 32'h0000_0F00);

    // 2. start pulse
    axi_write(12'h000, 32'h0000_0F01, 4'hF, resp, st);
    chk("t2_start_pulse", {28'd0, st}, 32'hF);
    chk("t2_start_gone",  {28'd0, tpc_start}, 32'd0);
    axi_read(12'h004, d, resp);
    chk("t2_status", d, 32'h0001_0000);
    axi_read(12'h000, d, resp);
    chk("t2_ctrl_rd", d, 32'h0000_0F00);

    // 3. done collection and interrupt
    axi_write(12'h00C, 32'h1, 4'h1, resp, st);
    tpc_done = 4'h1; @(negedge clk);
    tpc_done = 4'h2; @(negedge clk);
    tpc_done = 4'h4; @(negedge clk);
    chk("t3_irq_partial", {31'd0, irq}, 32'd0);
    tpc_done = 4'h8; @(negedge clk);
    tpc_done = 4'h0;
    chk("t3_irq_not_yet", {31'd0, irq}, 32'd0);
    @(negedge clk);
    chk("t3_irq_set", {31'd0, irq}, 32'd1);
    axi_read(12'h004, d, resp);
    chk("t3_status", d, 32'h0000_0F00);
    axi_read(12'h008, d, resp);
    chk("t3_pend", d, 32'd1);
    axi_write(12'h008, 32'h1, 4'h1, resp, st);
    chk("t3_irq_clr", {31'd0, irq}, 32'd0);

    // 4. AW three cycles ahead of W, B held off for 5 cycles
    awaddr = 12'h000; wdata = 32'h0000_0500; wstrb = 4'h2; awvalid = 1'b1; bready = 1'b0;
    chk("t4_awready", {31'd0, awready}, 32'd1);
    @(negedge clk);
    awvalid = 1'b0;
    chk("t4_aw_closed", {31'd0, awready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("t4_no_commit", {28'd0, tpc_enable}, 32'hF);
    wvalid = 1'b1;
    chk("t4_wready", {31'd0, wready}, 32'd1);
    @(negedge clk);
    wvalid = 1'b0;
    chk("t4_enable", {28'd0, tpc_enable}, 32'h5);
    bcnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (bvalid && !awready && !wready) bcnt++;
      if (i < 4) @(negedge clk);
    end
    chk("t4_bvalid_hold", bcnt, 32'd5);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("t4_bvalid_low", {31'd0, bvalid}, 32'd0);
    chk("t4_reopen", {30'd0, awready, wready}, 32'd3);
    axi_read(12'h000, d, resp);
    chk("t4_ctrl_rd", d, 32'h0000_0500);

    // 5. unmapped address, VERSION
    axi_read(12'h020, d, resp);
    chk("t5_rd_resp", {30'd0, resp}, 32'd2);
    chk("t5_rd_data", d, 32'd0);
    axi_write(12'h020, 32'hFFFF_FFFF, 4'hF, resp, st);
    chk("t5_wr_resp", {30'd0, resp}, 32'd2);
    chk("t5_enable_kept", {28'd0, tpc_enable}, 32'h5);
    axi_read(12'h00C, d, resp);
    chk("t5_irq_en_kept", d, 32'd1);
    axi_read(12'h010, d, resp);
    chk("t5_version", d, 32'h0001_0000);

    // 6. reset while a response is pending
    awaddr = 12'h000; wdata = 32'h0000_0F00; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    chk("t6_bvalid_pending", {31'd0, bvalid}, 32'd1);
    chk("t6_enable_f", {28'd0, tpc_enable}, 32'hF);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_bvalid", {31'd0, bvalid}, 32'd0);
    chk("t6_rst_enable", {28'd0, tpc_enable}, 32'd0);
    chk("t6_rst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    axi_write(12'h000, 32'h0000_0300, 4'hF, resp, st);
    chk("t6_after_bresp", {30'd0, resp}, 32'd0);
    chk("t6_after_enable", {28'd0, tpc_enable}, 32'h3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
